// File: rtl/uart_tx_bridge_if.sv
// Write-side handshake between the core's byte port and the UART TX bridge.
// The core drives {valid,byte} on wr_arg; the bridge returns ready on wr_out.
interface uart_tx_bridge_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W:0] wr_arg;
  logic            wr_out;

  modport master (output wr_arg, input  wr_out);
  modport slave  (input  wr_arg, output wr_out);
endinterface

// File: rtl/uart_tx_bridge.sv
// Buffered UART transmitter: FIFO-fed, LSB-first start/data/[parity]/stop frames.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_bridge #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                              CLK,
  input  logic                              RST,
  uart_tx_bridge_if.slave                   wr,
  output logic                              uart_line_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              tx_busy,
  output logic                              tx_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = $clog2(STOP_BITS*CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS*CLKS_PER_BIT-1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W-1);

  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      CLKS_PER_BIT < 2) begin : g_bad_cfg
    $error("uart_tx_bridge: unsupported STOP_BITS/PARITY_ODD/CLKS_PER_BIT");
  end

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wp, rp;
  logic              push, pop;

  // Ready depends only on the registered level: a pop frees a slot next cycle.
  assign wr.wr_out = (fifo_level != FULL);
  assign push      = wr.wr_arg[DATA_W] && wr.wr_out;

  always_ff @(posedge CLK)
    if (push) mem[wp] <= wr.wr_arg[DATA_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- serialiser FSM ----------------
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d, idx_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic              line_q, line_d;
  logic              cnt_zero, fifo_ne;

  assign cnt_zero = (cnt_q == '0);
  assign fifo_ne  = (fifo_level != '0);
  assign idx_inc  = idx_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    line_d  = line_q;
    pop     = 1'b0;
    tx_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        if (fifo_ne) begin
          pop     = 1'b1;
          data_d  = mem[rp];
          line_d  = 1'b0;
          cnt_d   = BIT_LAST;
          state_d = S_START;
        end
      end
      S_START:
        if (cnt_zero) begin
          line_d  = data_q[0];
          idx_d   = '0;
          cnt_d   = BIT_LAST;
          state_d = S_DATA;
        end
      S_DATA:
        if (cnt_zero) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            line_d  = ^data_q ^ PAR_ODD;
            cnt_d   = BIT_LAST;
            state_d = S_PARITY;
`else
            line_d  = 1'b1;
            cnt_d   = STOP_LAST;
            state_d = S_STOP;
`endif
          end else begin
            idx_d  = idx_inc;
            line_d = data_q[idx_inc];
            cnt_d  = BIT_LAST;
          end
        end
      S_PARITY:
        if (cnt_zero) begin
          line_d  = 1'b1;
          cnt_d   = STOP_LAST;
          state_d = S_STOP;
        end
      S_STOP:
        if (cnt_zero) begin
          tx_done = 1'b1;
          // Chain straight into the next start bit when more data is waiting.
          if (fifo_ne) begin
            pop     = 1'b1;
            data_d  = mem[rp];
            line_d  = 1'b0;
            cnt_d   = BIT_LAST;
            state_d = S_START;
          end else begin
            line_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      default: begin
        line_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign uart_line_out = line_q;
  assign tx_busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx_bridge.sv
// Scoreboard bench for uart_tx_bridge: stimulus queues expected bytes, a line
// receiver decodes frames and compares them; directed checks cover timing/flags.
module tb_uart_tx_bridge;
  localparam int CPB  = 4;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif
  localparam int FRAME = (1 + 8 + PBIT + 1) * CPB;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       uart_line_out, tx_busy, tx_done;
  logic [4:0] fifo_level;

  uart_tx_bridge_if #(.DATA_W(8)) bus ();

  uart_tx_bridge #(
    .DATA_W(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(PODD)
  ) dut (
    .CLK(CLK), .RST(RST), .wr(bus), .uart_line_out(uart_line_out),
    .fifo_level(fifo_level), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         rst_gen = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] b, output int waited);
    bus.wr_arg = {1'b1, b};
    waited = 0;
    while (bus.wr_out !== 1'b1 && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 500) chk("push_timeout", {31'd0, bus.wr_out}, 32'd1);
    @(posedge CLK);
    exp_q.push_back(b);
    #1 bus.wr_arg = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while ((tx_busy !== 1'b0 || fifo_level !== 5'd0) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", {31'd0, tx_busy}, 32'd0);
    repeat (4) @(negedge CLK);
  endtask

  task automatic busy_len(output int n);
    int w = 0;
    @(negedge CLK);
    while (tx_busy !== 1'b1 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    n = 0;
    while (tx_busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    if (tx_done === 1'b1) done_cnt++;
  end

  // Line receiver: samples each bit mid-way, scores frames against exp_q.
  initial begin
    int         gen;
    logic       st, sp, par;
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (uart_line_out === 1'b0 && RST === 1'b0) begin
        gen = rst_gen;
        par = 1'b0;
        @(negedge CLK);
        st = uart_line_out;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = uart_line_out;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge CLK);
        par = uart_line_out;
`endif
        repeat (CPB) @(negedge CLK);
        sp = uart_line_out;
        if (gen == rst_gen) begin
          chk("frame_start", {31'd0, st}, 32'd0);
          chk("frame_stop", {31'd0, sp}, 32'd1);
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", {24'd0, b}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
            chk("frame_parity", {31'd0, par}, {31'd0, ^e ^ (PODD != 0)});
`else
            chk("frame_parity_unused", {31'd0, par}, 32'd0);
`endif
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, d0, bad;
    bus.wr_arg = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_line", {31'd0, uart_line_out}, 32'd1);
    chk("rst_ready", {31'd0, bus.wr_out}, 32'd1);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 1: single frame, latency and done/busy timing
    d0 = done_cnt;
    push_word(8'h55, w);
    chk("t1_level_after_push", {27'd0, fifo_level}, 32'd1);
    chk("t1_line_still_high", {31'd0, uart_line_out}, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("t1_line_falls", {31'd0, uart_line_out}, 32'd0);
    chk("t1_busy", {31'd0, tx_busy}, 32'd1);
    chk("t1_level_popped", {27'd0, fifo_level}, 32'd0);
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("t1_done_time", n, FRAME - 1);
    @(negedge CLK);
    chk("t1_done_pulse", {31'd0, tx_done}, 32'd0);
    chk("t1_busy_falls", {31'd0, tx_busy}, 32'd0);
    chk("t1_line_idle", {31'd0, uart_line_out}, 32'd1);
    wait_idle();
    chk("t1_done_count", done_cnt - d0, 1);

    // 2: valid=0 is never pushed
    bus.wr_arg = 9'h0AA;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (fifo_level !== 5'd0 || uart_line_out !== 1'b1 || bus.wr_out !== 1'b1) bad++;
    end
    bus.wr_arg = '0;
    chk("t2_novalid_hold", bad, 0);

    // 4: back-to-back frames with no idle gap
    d0 = done_cnt;
    push_word(8'hA5, w);
    push_word(8'h3C, w);
    busy_len(n);
    chk("t4_busy_span", n, 2 * FRAME);
    wait_idle();
    chk("t4_done_count", done_cnt - d0, 2);

    // 3: fill the FIFO, backpressure, ready returns after the next pop
    for (int i = 0; i < 17; i++) push_word(8'(8'h10 + i), w);
    chk("t3_level_full", {27'd0, fifo_level}, 32'd16);
    chk("t3_ready_low", {31'd0, bus.wr_out}, 32'd0);
    push_word(8'hEE, w);
    chk("t3_hold_cycles", w, FRAME - 14);
    wait_idle();

    // 5: reset mid-DATA of the third byte with 5 still queued
    for (int i = 0; i < 8; i++) push_word(8'(8'hC0 + i), w);
    repeat (2 * FRAME + 10) @(negedge CLK);
    chk("t5_level_queued", {27'd0, fifo_level}, 32'd5);
    chk("t5_busy_mid", {31'd0, tx_busy}, 32'd1);
    RST = 1'b1;
    rst_gen++;
    exp_q.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("t5_line_high", {31'd0, uart_line_out}, 32'd1);
    chk("t5_level_cleared", {27'd0, fifo_level}, 32'd0);
    chk("t5_busy_cleared", {31'd0, tx_busy}, 32'd0);
    chk("t5_ready", {31'd0, bus.wr_out}, 32'd1);
    repeat (FRAME + 20) @(negedge CLK);
    d0 = done_cnt;
    push_word(8'h3C, w);
    wait_idle();
    chk("t5_recover_done", done_cnt - d0, 1);

`ifdef UART_TX_PARITY_EN
    // 6: parity frame length (parity value is scored by the receiver)
    push_word(8'h07, w);
    busy_len(n);
    chk("t6_frame_len", n, 44);
    wait_idle();
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
